// File: rtl/muldiv_if.sv
// Execute-stage handshake for the iterative RV64M multiply/divide sequencer.
// The execute stage is the master; the sequencer is the slave.
interface muldiv_if;
    logic        valid;
    logic [2:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [63:0] result;

    modport master (output valid, op, word, a, b, flush, input stall, done, result);
    modport slave  (input valid, op, word, a, b, flush, output stall, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide: shift-add multiply and restoring divide, one bit
// per cycle. Freezes the pipeline via stall and pulses done with a registered result.
module muldiv_seq (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    typedef logic [63:0] word_t;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    function automatic word_t fin(input word_t v, input logic w);
        return w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    state_t     state, state_nx;
    word_t      acc, acc_nx;     // product, or partial remainder
    word_t      sh, sh_nx;       // multiplicand, or dividend shifting into quotient
    word_t      dv, dv_nx;       // multiplier, or divisor
    logic [6:0] count, count_nx;
    logic       word_q, word_nx, rem_q, rem_nx;
    logic       neg_quo_q, neg_quo_nx, neg_rem_q, neg_rem_nx;
    word_t      result_q, result_nx;

    logic        sgn, reserved, div_zero, ovf, ge;
    word_t       ext_a, ext_b, abs_a, abs_b, min_neg, fast_res, q_fin, r_fin;
    logic [64:0] shifted;

    always_comb begin : decode
        sgn   = !bus.op[0];
        ext_a = bus.a;
        ext_b = bus.b;
        if (bus.word) begin
            ext_a = sgn ? {{32{bus.a[31]}}, bus.a[31:0]} : {32'b0, bus.a[31:0]};
            ext_b = sgn ? {{32{bus.b[31]}}, bus.b[31:0]} : {32'b0, bus.b[31:0]};
        end
        min_neg  = bus.word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        reserved = !bus.op[2] && (bus.op[1:0] != 2'b00);
        div_zero = bus.op[2] && (ext_b == '0);
        ovf      = bus.op[2] && sgn && (ext_a == min_neg) && (ext_b == '1);
        abs_a    = (sgn && ext_a[63]) ? -ext_a : ext_a;
        abs_b    = (sgn && ext_b[63]) ? -ext_b : ext_b;
        fast_res = '0;
        if (div_zero)
            fast_res = bus.op[1] ? ext_a : '1;
        else if (ovf)
            fast_res = bus.op[1] ? '0 : ext_a;
        fast_res = fin(fast_res, bus.word);
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin : next
        state_nx   = state;
        acc_nx     = acc;
        sh_nx      = sh;
        dv_nx      = dv;
        count_nx   = count;
        word_nx    = word_q;
        rem_nx     = rem_q;
        neg_quo_nx = neg_quo_q;
        neg_rem_nx = neg_rem_q;
        result_nx  = result_q;
        shifted    = {acc, sh[63]};
        ge         = shifted[64] || (shifted[63:0] >= dv);
        q_fin      = '0;
        r_fin      = '0;

        case (state)
            S_IDLE: if (bus.valid) begin
                word_nx    = bus.word;
                rem_nx     = bus.op[1];
                neg_quo_nx = sgn && (ext_a[63] ^ ext_b[63]);
                neg_rem_nx = sgn && ext_a[63];
                acc_nx     = '0;
                count_nx   = bus.word ? 7'd32 : 7'd64;
                if (reserved || div_zero || ovf) begin
                    result_nx = fast_res;
                    count_nx  = '0;
                    state_nx  = S_DONE;
                end else if (bus.op[2]) begin
                    // Word dividends start in the top half so 32 shifts bring them into rem.
                    sh_nx    = bus.word ? {abs_a[31:0], 32'b0} : abs_a;
                    dv_nx    = abs_b;
                    state_nx = S_DIV;
                end else begin
                    sh_nx    = ext_a;
                    dv_nx    = ext_b;
                    state_nx = S_MUL;
                end
            end
            S_MUL: begin
                acc_nx   = dv[0] ? acc + sh : acc;
                sh_nx    = {sh[62:0], 1'b0};
                dv_nx    = {1'b0, dv[63:1]};
                count_nx = count - 7'd1;
                if (count == 7'd1) begin
                    result_nx = fin(acc_nx, word_q);
                    state_nx  = S_DONE;
                end
            end
            S_DIV: begin
                acc_nx   = ge ? shifted[63:0] - dv : shifted[63:0];
                sh_nx    = {sh[62:0], ge};
                count_nx = count - 7'd1;
                q_fin    = neg_quo_q ? -sh_nx : sh_nx;
                r_fin    = neg_rem_q ? -acc_nx : acc_nx;
                if (count == 7'd1) begin
                    result_nx = fin(rem_q ? r_fin : q_fin, word_q);
                    state_nx  = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // A redirect kills the op in flight and never disturbs the visible result.
        if (bus.flush) begin
            state_nx  = S_IDLE;
            result_nx = result_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            acc       <= '0;
            sh        <= '0;
            dv        <= '0;
            count     <= '0;
            word_q    <= 1'b0;
            rem_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            sh        <= sh_nx;
            dv        <= dv_nx;
            count     <= count_nx;
            word_q    <= word_nx;
            rem_q     <= rem_nx;
            neg_quo_q <= neg_quo_nx;
            neg_rem_q <= neg_rem_nx;
            result_q  <= result_nx;
        end
    end

    assign bus.stall  = bus.valid && !bus.flush && (state != S_DONE) && !reset;
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed spec cases, flush/reset aborts,
// back-to-back issue and randomized ops against an arithmetic reference model.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    muldiv_if bus ();

    muldiv_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    // Reference result computed with plain signed/unsigned arithmetic plus the RISC-V special cases.
    function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        int              sa, sb;
        int unsigned     ua, ub;
        longint          la, lb;
        longint unsigned xa, xb;
        logic [31:0]     r32;
        logic [63:0]     r;
        logic            ovf32, ovf64;
        sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        la = a; lb = b; xa = a; xb = b;
        ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        r32 = '0;
        r   = '0;
        if (w) begin
            case (op)
                3'd0: r32 = ua * ub;
                3'd4: if (ub == 0) r32 = '1; else if (ovf32) r32 = a[31:0]; else r32 = sa / sb;
                3'd5: if (ub == 0) r32 = '1; else r32 = ua / ub;
                3'd6: if (ub == 0) r32 = a[31:0]; else if (ovf32) r32 = '0; else r32 = sa % sb;
                3'd7: if (ub == 0) r32 = a[31:0]; else r32 = ua % ub;
                default: r32 = '0;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (op)
                3'd0: r = xa * xb;
                3'd4: if (xb == 0) r = '1; else if (ovf64) r = a; else r = la / lb;
                3'd5: if (xb == 0) r = '1; else r = xa / xb;
                3'd6: if (xb == 0) r = a; else if (ovf64) r = '0; else r = la % lb;
                3'd7: if (xb == 0) r = a; else r = xa % xb;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // Cycles from the first valid cycle to done: 1 on the fast path, else iterations + 1.
    function automatic int exp_lat(input logic [2:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf;
        if (op == 3'd1 || op == 3'd2 || op == 3'd3) return 1;
        if (op == 3'd0) return w ? 33 : 65;
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = (op == 3'd4 || op == 3'd6) &&
               (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                  : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
        return (zero || ovf) ? 1 : (w ? 33 : 65);
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_8000_0000;
            4: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Presents one op with valid held and observes it until done (bounded).
    task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] res,
                          output int lat, output int stalls, output logic ok);
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.op = op; bus.word = w; bus.a = a; bus.b = b;
        lat = 0; stalls = 0; ok = 1'b0; res = '0;
        for (int i = 1; i <= 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.stall) stalls++;
            if (bus.done) begin
                ok  = 1'b1;
                lat = i - 1;
                res = bus.result;
            end
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        bus.valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.valid = 1'b1; bus.op = 3'd0; bus.word = 1'b0;
        bus.a = 64'd5; bus.b = 64'd5; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_vec++; if (bus.result !== 64'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", bus.result); end
        bus.valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.done !== 1'b0 || bus.stall !== 1'b0) begin
            n_err++; $display("FAIL post_reset_idle: got done=%b stall=%b want 0 0", bus.done, bus.stall);
        end
    endtask

    task automatic test_directed();
        vec_t        tbl[8];
        logic [63:0] res;
        int          lat, stalls;
        logic        ok;
        tbl[0] = '{3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65};
        tbl[1] = '{3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        tbl[2] = '{3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        tbl[3] = '{3'd5, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        tbl[4] = '{3'd7, 1'b0, 64'd100, 64'd0, 64'd100, 1};
        tbl[5] = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        tbl[6] = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
        tbl[7] = '{3'd2, 1'b0, 64'd5, 64'd7, 64'd0, 1};
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].op, tbl[i].w, tbl[i].a, tbl[i].b, res, lat, stalls, ok);
            n_vec++;
            if (!ok) begin
                n_err++; $display("FAIL dir%0d_timeout: got no done want done", i);
            end else begin
                n_vec++; if (res !== tbl[i].exp) begin n_err++; $display("FAIL dir%0d_result: got %h want %h", i, res, tbl[i].exp); end
                n_vec++; if (lat != tbl[i].lat) begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tbl[i].lat); end
                n_vec++; if (stalls != tbl[i].lat) begin n_err++; $display("FAIL dir%0d_stall_cycles: got %0d want %0d", i, stalls, tbl[i].lat); end
            end
            idle(3);
            @(negedge clk);
            n_vec++; if (bus.result !== tbl[i].exp) begin n_err++; $display("FAIL dir%0d_held: got %h want %h", i, bus.result, tbl[i].exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int          lat, stalls;
        logic        ok;
        run_op(3'd0, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, res, lat, stalls, ok);
        n_vec++; if (!ok || res !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            n_err++; $display("FAIL b2b_first: got ok=%b %h want ok=1 ffffffffffffffeb", ok, res);
        end
        run_op(3'd0, 1'b1, 64'h1_0000, 64'h1_0000, res, lat, stalls, ok);
        n_vec++; if (!ok || res !== 64'd0) begin
            n_err++; $display("FAIL b2b_second: got ok=%b %h want ok=1 0", ok, res);
        end
        n_vec++; if (lat != 33) begin n_err++; $display("FAIL b2b_second_latency: got %0d want 33", lat); end
        idle(2);
    endtask

    task automatic test_valid_drop();
        logic [63:0] a, b, exp;
        logic        seen;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom} | 64'd1;
        exp = model(3'd5, 1'b0, a, b);
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.op = 3'd5; bus.word = 1'b0; bus.a = a; bus.b = b;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 bus.valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        n_vec++; if (!seen || bus.result !== exp) begin
            n_err++; $display("FAIL valid_drop: got done=%b %h want done=1 %h", seen, bus.result, exp);
        end
        idle(2);
    endtask

    task automatic test_random();
        logic [63:0] a, b, res, exp;
        logic [2:0]  op;
        logic        w, ok;
        int          lat, stalls, el;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1: op = 3'd0;
                2, 7: op = 3'd4;
                3:    op = 3'd5;
                4, 8: op = 3'd6;
                5:    op = 3'd7;
                6:    op = 3'($urandom_range(1, 3));
                default: op = 3'd5;
            endcase
            w = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            exp = model(op, w, a, b);
            el  = exp_lat(op, w, a, b);
            run_op(op, w, a, b, res, lat, stalls, ok);
            n_vec++;
            if (!ok || res !== exp || lat != el || stalls != el) begin
                n_err++;
                $display("FAIL rand%0d op=%0d w=%0d a=%h b=%h: got ok=%b %h lat=%0d stall=%0d want %h lat=%0d",
                         i, op, w, a, b, ok, res, lat, stalls, exp, el);
            end
            idle(1);
        end
    endtask

    task automatic test_flush();
        logic [63:0] res;
        int          lat, stalls;
        logic        ok, saw_done, held;
        run_op(3'd5, 1'b0, 64'd1000, 64'd7, res, lat, stalls, ok);
        n_vec++; if (!ok || res !== 64'd142) begin n_err++; $display("FAIL flush_setup: got ok=%b %h want ok=1 142", ok, res); end
        idle(1);
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.op = 3'd4; bus.word = 1'b0; bus.a = 64'd123456789; bus.b = 64'd3;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", bus.stall); end
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.valid = 1'b0;
        // Flush coinciding with an accept must not start the op.
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.flush = 1'b1; bus.op = 3'd0; bus.a = 64'd9; bus.b = 64'd9;
        @(negedge clk);
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL flush_accept_stall: got %b want 0", bus.stall); end
        @(posedge clk); #1;
        bus.valid = 1'b0; bus.flush = 1'b0;
        saw_done = 1'b0; held = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
            if (bus.result !== 64'd142) held = 1'b0;
        end
        n_vec++; if (saw_done) begin n_err++; $display("FAIL flush_no_done: got done pulse want none"); end
        n_vec++; if (!held) begin n_err++; $display("FAIL flush_result_held: got %h want 142", bus.result); end
        run_op(3'd0, 1'b0, 64'd6, 64'd7, res, lat, stalls, ok);
        n_vec++; if (!ok || res !== 64'd42 || lat != 65) begin
            n_err++; $display("FAIL flush_then_mul: got ok=%b %h lat=%0d want 42 lat=65", ok, res, lat);
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.op = 3'd0; bus.word = 1'b0; bus.a = 64'd11; bus.b = 64'd13;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL mid_reset_stall: got %b want 0", bus.stall); end
        @(posedge clk); #1;
        reset = 1'b0; bus.valid = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.result !== 64'd0 || bus.done !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_outputs: got done=%b %h want 0 0", bus.done, bus.result);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        n_vec++; if (saw_done) begin n_err++; $display("FAIL mid_reset_no_done: got done pulse want none"); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_valid_drop();
        test_random();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative RV64M multiply/divide sequencer for the execute stage. When the execute stage holds an M-extension instruction, it accepts the operands, runs a shift-add multiply or a restoring divide one bit per cycle, and holds `stall` high to freeze the pipeline. On completion it pulses `done` with the 64-bit result, which the execute stage muxes in place of the ALU result. `flush` aborts an operation in flight.

## Interface
- No parameters; data width fixed at 64 (`word_t`).
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- valid  in  1  execute stage holds an M op with final (forwarded) operands
- op  in  3  0=MUL, 4=DIV, 5=DIVU, 6=REM, 7=REMU; 1–3 reserved
- word  in  1  32-bit W variant (MULW/DIVW/DIVUW/REMW/REMUW)
- a  in  64  rs1 operand
- b  in  64  rs2 operand
- flush  in  1  abort current op (branch/jump redirect)
- stall  out  1  freeze fetch/decode/execute registers
- done  out  1  one-cycle result-valid pulse
- result  out  64  result; held until the next accept

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE, `valid & !flush`: latch operands and op.
  - Reserved op, divide-by-zero, or signed overflow → DONE (fast path).
  - Otherwise set count = 64 (32 if `word`) and go to MUL or DIV.
- Word ops:
  - Operands truncated to [31:0], then sign-extended (MUL, DIV, REM) or zero-extended (DIVU, REMU).
  - Final result is sign-extended from bit 31.
- Signed divide:
  - Iterate on absolute values.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- MUL iteration:
  - Add multiplicand to the accumulator if the multiplier LSB is 1.
  - Shift multiplicand left and multiplier right.
  - Keep the low 64 bits only.
- DIV iteration:
  - Shift {rem, quo} left by 1 and trial-subtract the divisor from rem.
  - If non-negative, keep the difference and set the quotient LSB.
- Count decrements each iteration. The iteration with count==1 moves to DONE.
- DONE: `done=1`, `result` valid, `stall=0`; always go to IDLE next cycle.
- Special results:
  - Divide by zero: quotient all ones; remainder = dividend (after word truncation/extension).
  - Overflow (most-negative / −1): quotient = dividend; remainder = 0.
  - Reserved op: result 0.
- `stall = valid & !flush & (state != DONE)`; forced 0 during reset.
- `flush` has priority over everything:
  - In any state, next state is IDLE, no `done`, and `result` is unchanged.
  - A flush in the same cycle as an accept suppresses the accept.
- `valid` falling while in MUL/DIV without `flush` is a protocol violation. The op still completes and `done` pulses.

## Timing
- Reset (synchronous): state=IDLE, count=0, done=0, result=0, stall=0, internal registers 0.
- Accept at cycle T (IDLE, valid, !flush):
  - Iterative path: iterations in T+1..T+N (N=64 or 32); `done` and `result` at T+N+1.
  - Latency: 65 cycles for doubleword ops, 33 for W ops.
  - `stall` is high T..T+N and low at T+N+1.
- Fast path: `done` at T+1; `stall` high at T only.
- Back-to-back: the pipeline advances on the DONE cycle, so the next M op can be accepted at T+N+2.
- Flush at cycle F during MUL/DIV: state=IDLE at F+1; `stall` low at F (combinational on `flush`).
- `result` is registered and held stable from DONE until the next accept.
- Reset mid-operation: returns to IDLE next edge, no `done`.

## Test plan
- MUL, a=3, b=−5 (0xFFFF…FFFB), valid held → `done` 65 cycles after accept, result=0xFFFFFFFFFFFFFFF1, `stall` high for exactly 65 cycles.
- DIVW a=0x…FFFFFFF9 (−7), b=2 → result=0xFFFFFFFFFFFFFFFD after 33 cycles; REMW with the same operands → 0xFFFFFFFFFFFFFFFF.
- DIVU a=100, b=0 → `done` at T+1, result=0xFFFFFFFFFFFFFFFF; REMU with the same operands → 100.
- DIV a=0x8000000000000000, b=−1 → `done` at T+1, result=0x8000000000000000; REM with the same operands → 0.
- Start DIV, assert `flush` at iteration 10 → no `done`, `stall` low in the flush cycle, IDLE next cycle, `result` still holds the previous value; a new MUL 6×7 is then accepted → 42.
- Two consecutive MULW ops (7×−3, then 0x10000×0x10000) → results 0xFFFFFFFFFFFFFFEB then 0 (W truncation), second accept exactly one cycle after the first `done`; reset asserted mid-op → outputs return to zero values.
